gpp_apb_arb: RTL and testbench
==============================

# gpp_apb_arb

Round-robin APB master that shares the single GPP register-bank APB slave between `NUM_REQ` on-chip requesters, such as test sequencers and debug bridges. It accepts one request at a time through a valid/ready handshake and runs a full APB setup→access transfer. It returns read data and error status to the winning requester, and aborts a transfer whose slave never asserts PREADY. It sits between the requesters and the GPP slave's APB port.

## Interface
- `NUM_REQ`, 2, number of requesters (2..8)
- `APB_ADDR_WIDTH`, 12, APB address width (4KB slave window)
- `TIMEOUT_CYCLES`, 16, maximum ACCESS-phase cycles without PREADY before abort; 0 disables the timeout
- Reset HRESETn, asynchronous, active-low; clock HCLK.
- `HCLK`  in  1  clock
- `HRESETn`  in  1  async active-low reset
- `req_valid`  in  NUM_REQ  per-requester transfer request
- `req_write`  in  NUM_REQ  1=write, 0=read
- `req_addr`  in  NUM_REQ×APB_ADDR_WIDTH  byte address
- `req_wdata`  in  NUM_REQ×32  write data
- `req_ready`  out  NUM_REQ  one-hot accept strobe
- `rsp_valid`  out  NUM_REQ  one-hot, 1-cycle completion pulse
- `rsp_rdata`  out  32  read data, valid with rsp_valid
- `rsp_err`  out  1  PSLVERR or timeout, valid with rsp_valid
- `PADDR`  out  APB_ADDR_WIDTH  APB address
- `PWDATA`  out  32  APB write data
- `PWRITE`  out  1  APB direction
- `PSEL`  out  1  APB select
- `PENABLE`  out  1  APB enable
- `PRDATA`  in  32  APB read data
- `PREADY`  in  1  APB ready
- `PSLVERR`  in  1  APB error

## Operation
- **FSM states.** IDLE, SETUP, ACCESS.
- **Reset values.** state=IDLE, rr pointer=0, counter=0. All outputs are 0: req_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWDATA, PWRITE, PSEL, PENABLE.
- **IDLE.**
  - PSEL=0, PENABLE=0.
  - If any req_valid is high, the winner is the first set bit searching upward from the pointer, with wrap.
  - `req_ready[winner]` is asserted combinationally in the same cycle.
  - At the clock edge, latch req_addr/req_wdata/req_write into PADDR/PWDATA/PWRITE and store the winner index.
  - Set pointer = winner+1, wrapping modulo NUM_REQ, then go to SETUP.
- **SETUP.** PSEL=1, PENABLE=0 for exactly 1 cycle, then go to ACCESS.
- **ACCESS.**
  - PSEL=1, PENABLE=1.
  - On PREADY=1:
    - Capture PRDATA into rsp_rdata; capture 0 instead if PWRITE=1.
    - Set rsp_err=PSLVERR.
    - Pulse `rsp_valid[winner]` in the next cycle.
    - Go to IDLE.
- **Timeout.**
  - The counter increments for each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYCLES, the transfer is aborted: PSEL and PENABLE drop, rsp_err=1, rsp_rdata=32'h0, rsp_valid pulses for the winner, and the FSM goes to IDLE.
  - The counter clears on leaving ACCESS.
- **Bus hold.** PADDR, PWDATA and PWRITE hold their latched values until the next grant; they are not cleared in IDLE.
- **Requester rules.**
  - A requester holds req_valid and its payload stable until req_ready.
  - Deasserting req_valid before req_ready is allowed and is a withdrawal.
  - A requester issues at most one outstanding request.
- **Simultaneous events.**
  - rsp_valid for transfer N and req_ready for transfer N+1 may be high in the same cycle.
  - If a requester raises req_valid in the cycle its own rsp_valid pulses, it is eligible for arbitration.
- **Reset mid-transfer.** PSEL and PENABLE drop asynchronously. No rsp_valid is issued for the aborted transfer.

## Timing
- **Zero-wait transfer.**
  - Cycle 0: accept (IDLE).
  - Cycle 1: SETUP.
  - Cycle 2: ACCESS, PREADY sampled.
  - Cycle 3: rsp_valid and IDLE.
  - Latency is 3 cycles; back-to-back throughput is one transfer per 3 cycles.
- **PSEL gap.** PSEL is low for at least 1 cycle between consecutive transfers. This is mandatory because the GPP slave derives its ready from the registered PSEL and performs only one write/read per PSEL assertion.
- **Wait states.** Each cycle of PREADY=0 extends ACCESS by 1 cycle.
- **Registered outputs.** APB signals, rsp_valid, rsp_rdata and rsp_err come directly from flops. req_ready is the only combinational output.

## Structure
- **`gpp_arb_pkg`.**
  - State enum typedef `gpp_arb_state_e` (IDLE/SETUP/ACCESS).
  - `GPP_ARB_TIMEOUT_DEFAULT`=16.
  - `GPP_ARB_ERR_RDATA`=32'h0.
- **`gpp_rr_pick` sub-module.** Combinational round-robin picker with inputs req vector and pointer, and outputs one-hot grant and index. The pointer register stays in the top-level module.
- **Counter width.** `$clog2(TIMEOUT_CYCLES+1)`, minimum 1 bit.

## Test plan
- **Single write.** Requester 0 writes 32'hA5A5_0001 to 12'h008. Expect PSEL for 2 cycles, PENABLE in the 2nd; rsp_valid[0] at cycle 3 with rsp_err=0; slave reg[2]=32'hA5A5_0001.
- **Readback.** Requester 1 reads 12'h008 after the write above. Expect rsp_rdata=32'hA5A5_0001 and rsp_valid=2'b10.
- **Contention.** Both requesters hold req_valid continuously from reset, writing reg[0]/reg[1]. Expect grants in order 0,1,0,1, with PSEL low ≥1 cycle between each pair.
- **Timeout.** Force PREADY=0 with TIMEOUT_CYCLES=4. Expect ACCESS for 4 cycles, then rsp_err=1, rsp_rdata=0, and PSEL low.
- **PSLVERR.** Force PSLVERR=1 with PREADY on a read. Expect rsp_err=1, and the next request proceeds normally.
- **Reset mid-transfer.** Assert HRESETn low during ACCESS. Expect PSEL/PENABLE=0 immediately, no rsp_valid, pointer=0, and the first post-reset grant goes to requester 0.

Source files
------------

// File: rtl/gpp_arb_pkg.sv
// Shared types and constants for the GPP register-bank APB arbiter.
package gpp_arb_pkg;

    localparam int unsigned GPP_ARB_DATA_W          = 32;
    localparam int unsigned GPP_ARB_TIMEOUT_DEFAULT = 16;
    localparam logic [GPP_ARB_DATA_W-1:0] GPP_ARB_ERR_RDATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } gpp_arb_state_e;

    // Timeout counter width; a disabled timeout still keeps a 1-bit counter.
    function automatic int unsigned gpp_arb_cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/gpp_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module gpp_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned IW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IW-1:0]      idx_o
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IW'((32'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                grant_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpp_apb_arb.sv
// Round-robin APB master sharing the GPP register-bank slave among NUM_REQ requesters.
module gpp_apb_arb
    import gpp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = GPP_ARB_TIMEOUT_DEFAULT
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*GPP_ARB_DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 req_ready,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [GPP_ARB_DATA_W-1:0]          rsp_rdata,
    output logic                               rsp_err,
    output logic [APB_ADDR_WIDTH-1:0]          PADDR,
    output logic [GPP_ARB_DATA_W-1:0]          PWDATA,
    output logic                               PWRITE,
    output logic                               PSEL,
    output logic                               PENABLE,
    input  logic [GPP_ARB_DATA_W-1:0]          PRDATA,
    input  logic                               PREADY,
    input  logic                               PSLVERR
);

    localparam int unsigned IW      = $clog2(NUM_REQ);
    localparam int unsigned CNT_W   = gpp_arb_cnt_w(TIMEOUT_CYCLES);
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);

    gpp_arb_state_e              state_q;
    logic [IW-1:0]               ptr_q;
    logic [IW-1:0]               widx_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [GPP_ARB_DATA_W-1:0]   pwdata_q;
    logic                        pwrite_q;
    logic                        psel_q;
    logic                        penable_q;
    logic [NUM_REQ-1:0]          rsp_valid_q;
    logic [GPP_ARB_DATA_W-1:0]   rsp_rdata_q;
    logic                        rsp_err_q;

    logic [NUM_REQ-1:0]          pick_grant;
    logic [IW-1:0]               pick_idx;
    logic [IW-1:0]               ptr_nxt;
    logic [APB_ADDR_WIDTH-1:0]   sel_addr;
    logic [GPP_ARB_DATA_W-1:0]   sel_wdata;
    logic                        sel_write;
    logic                        timeout_hit;

    gpp_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx)
    );

    // Payload of the current winner.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_grant[i]) begin
                sel_addr  = req_addr[i*APB_ADDR_WIDTH +: APB_ADDR_WIDTH];
                sel_wdata = req_wdata[i*GPP_ARB_DATA_W +: GPP_ARB_DATA_W];
                sel_write = req_write[i];
            end
        end
    end

    assign ptr_nxt     = (pick_idx == IW'(NUM_REQ - 1)) ? '0 : pick_idx + IW'(1);
    assign timeout_hit = TO_EN && (cnt_q == CNT_W'(TO_LAST));
    assign req_ready   = (state_q == IDLE) ? pick_grant : '0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            widx_q      <= '0;
            cnt_q       <= '0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        paddr_q  <= sel_addr;
                        pwdata_q <= sel_wdata;
                        pwrite_q <= sel_write;
                        widx_q   <= pick_idx;
                        ptr_q    <= ptr_nxt;
                        psel_q   <= 1'b1;
                        state_q  <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_rdata_q         <= pwrite_q ? '0 : PRDATA;
                        rsp_err_q           <= PSLVERR;
                        rsp_valid_q[widx_q] <= 1'b1;
                        psel_q              <= 1'b0;
                        penable_q           <= 1'b0;
                        cnt_q               <= '0;
                        state_q             <= IDLE;
                    end else if (timeout_hit) begin
                        rsp_rdata_q         <= GPP_ARB_ERR_RDATA;
                        rsp_err_q           <= 1'b1;
                        rsp_valid_q[widx_q] <= 1'b1;
                        psel_q              <= 1'b0;
                        penable_q           <= 1'b0;
                        cnt_q               <= '0;
                        state_q             <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;

endmodule

// File: tb/tb_gpp_apb_arb.sv
// Scoreboard bench for gpp_apb_arb against a small APB register-bank slave model.
module tb_gpp_apb_arb;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 12;

    logic            HCLK;
    logic            HRESETn;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   PADDR;
    logic [31:0]     PWDATA;
    logic            PWRITE;
    logic            PSEL;
    logic            PENABLE;
    logic [31:0]     PRDATA;
    logic            PREADY;
    logic            PSLVERR;

    logic        v [N];
    logic        w [N];
    logic [11:0] a [N];
    logic [31:0] d [N];

    assign req_valid = {v[1], v[0]};
    assign req_write = {w[1], w[0]};
    assign req_addr  = {a[1], a[0]};
    assign req_wdata = {d[1], d[0]};

    gpp_apb_arb #(.NUM_REQ(N), .APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Slave model: zero-wait register bank, with knobs to hang PREADY or force PSLVERR.
    logic [31:0] mem [16];
    logic        s_hang;
    logic        s_err;
    assign PREADY  = PSEL && PENABLE && !s_hang;
    assign PRDATA  = mem[PADDR[5:2]];
    assign PSLVERR = s_err;
    always @(posedge HCLK) if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[5:2]] <= PWDATA;

    typedef struct {
        logic [N-1:0] vld;
        logic [31:0]  rdata;
        logic         err;
    } exp_t;
    exp_t q [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input int idx, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wd, input logic [31:0] er, input logic ee,
                          input bit push);
        int n;
        exp_t e;
        n = 0;
        v[idx] = 1'b1; w[idx] = wr; a[idx] = addr; d[idx] = wd;
        do begin
            @(negedge HCLK);
            n++;
        end while (!req_ready[idx] && n < 50);
        chk("accept", 32'(req_ready[idx]), 32'd1);
        if (push) begin
            e.vld = '0;
            e.vld[idx] = 1'b1;
            e.rdata = er;
            e.err = ee;
            q.push_back(e);
        end
        @(posedge HCLK);
        #1 v[idx] = 1'b0;
    endtask

    // Both requesters contend; records PSEL per cycle and grant order, expects write responses.
    task automatic contend(input int ncyc, output logic [31:0] psel_bits,
                           output logic [15:0] order, output int ngr);
        exp_t e;
        psel_bits = '0; order = '0; ngr = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge HCLK);
            psel_bits = {psel_bits[30:0], PSEL};
            if (req_ready != '0) begin
                order = {order[13:0], req_ready};
                ngr++;
                e.vld = req_ready; e.rdata = 32'h0; e.err = 1'b0;
                q.push_back(e);
            end
        end
        @(posedge HCLK);
        #1 v[0] = 1'b0; v[1] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge HCLK);
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        @(posedge HCLK);
        #1;
    endtask

    initial begin
        logic [31:0] pb;
        logic [15:0] ord;
        int ng;
        int pen;
        exp_t e;

        HRESETn = 1'b0; s_hang = 1'b0; s_err = 1'b0;
        for (int i = 0; i < N; i++) begin v[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0; end

        fork
            // Response monitor
            forever begin
                @(negedge HCLK);
                if (rsp_valid != '0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                        chk("rsp_rdata", rsp_rdata, e.rdata);
                        chk("rsp_err", 32'(rsp_err), 32'(e.err));
                    end
                end
            end
            begin
                #200000;
                chk("watchdog", 32'd1, 32'd0);
            end
            begin
                repeat (3) @(posedge HCLK);
                #1 HRESETn = 1'b1;
                @(negedge HCLK);
                chk("rst_psel", 32'(PSEL), 0);
                chk("rst_penable", 32'(PENABLE), 0);
                chk("rst_req_ready", 32'(req_ready), 0);
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_rsp_err", 32'(rsp_err), 0);
                chk("rst_paddr", 32'(PADDR), 0);
                chk("rst_pwdata", PWDATA, 0);
                chk("rst_pwrite", 32'(PWRITE), 0);
                @(posedge HCLK); #1;

                // Single write with APB phase timing
                do_req(0, 1'b1, 12'h008, 32'hA5A5_0001, 32'h0, 1'b0, 1'b1);
                @(negedge HCLK);
                chk("setup_psel", 32'(PSEL), 1);
                chk("setup_penable", 32'(PENABLE), 0);
                chk("setup_paddr", 32'(PADDR), 32'h008);
                chk("setup_pwdata", PWDATA, 32'hA5A5_0001);
                chk("setup_pwrite", 32'(PWRITE), 1);
                @(negedge HCLK);
                chk("access_psel", 32'(PSEL), 1);
                chk("access_penable", 32'(PENABLE), 1);
                @(negedge HCLK);
                chk("done_psel", 32'(PSEL), 0);
                chk("done_penable", 32'(PENABLE), 0);
                drain();
                chk("mem2", mem[2], 32'hA5A5_0001);

                // Readback by requester 1, then bus hold in IDLE
                do_req(1, 1'b0, 12'h008, 32'h0, 32'hA5A5_0001, 1'b0, 1'b1);
                drain();
                chk("hold_paddr", 32'(PADDR), 32'h008);
                chk("hold_pwrite", 32'(PWRITE), 0);

                // Contention from reset
                HRESETn = 1'b0;
                v[0] = 1'b1; w[0] = 1'b1; a[0] = 12'h000; d[0] = 32'h1111_0000;
                v[1] = 1'b1; w[1] = 1'b1; a[1] = 12'h004; d[1] = 32'h2222_0001;
                @(posedge HCLK);
                #1 HRESETn = 1'b1;
                contend(12, pb, ord, ng);
                chk("cont_psel_pattern", pb, 32'h0000_06DB);
                chk("cont_order", 32'(ord), 32'h66);
                chk("cont_ngrants", 32'(ng), 4);
                drain();
                chk("mem0", mem[0], 32'h1111_0000);
                chk("mem1", mem[1], 32'h2222_0001);

                // Timeout: PREADY never asserted
                s_hang = 1'b1;
                do_req(0, 1'b0, 12'h000, 32'h0, 32'h0, 1'b1, 1'b1);
                pen = 0;
                for (int c = 0; c < 20; c++) begin
                    @(negedge HCLK);
                    if (PENABLE) pen++;
                    else if (pen > 0) break;
                end
                chk("to_access_cycles", 32'(pen), 4);
                chk("to_psel_low", 32'(PSEL), 0);
                s_hang = 1'b0;
                drain();

                // PSLVERR on a read, then a normal read
                s_err = 1'b1;
                do_req(1, 1'b0, 12'h004, 32'h0, 32'h2222_0001, 1'b1, 1'b1);
                drain();
                s_err = 1'b0;
                do_req(0, 1'b0, 12'h000, 32'h0, 32'h1111_0000, 1'b0, 1'b1);
                drain();

                // Reset during ACCESS: no response, pointer back to 0
                s_hang = 1'b1;
                do_req(0, 1'b1, 12'h010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
                @(negedge HCLK);
                @(negedge HCLK);
                chk("pre_rst_penable", 32'(PENABLE), 1);
                #2 HRESETn = 1'b0;
                #1;
                chk("mid_rst_psel", 32'(PSEL), 0);
                chk("mid_rst_penable", 32'(PENABLE), 0);
                chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
                s_hang = 1'b0;
                v[0] = 1'b1; w[0] = 1'b1; a[0] = 12'h000; d[0] = 32'h3333_0000;
                v[1] = 1'b1; w[1] = 1'b1; a[1] = 12'h004; d[1] = 32'h4444_0001;
                @(posedge HCLK);
                #1 HRESETn = 1'b1;
                contend(6, pb, ord, ng);
                chk("post_rst_psel_pattern", pb, 32'h0000_001B);
                chk("post_rst_order", 32'(ord), 32'h6);
                drain();
                chk("post_rst_mem0", mem[0], 32'h3333_0000);
                chk("post_rst_mem1", mem[1], 32'h4444_0001);
                repeat (4) @(negedge HCLK);
            end
        join_any

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
